// File: rtl/pe_cfg_sequencer_if.sv
// ---------------------------------------------------------------------------
// pe_cfg_sequencer_if
//
// Instruction stream interface between the host/DMA side and the PE
// configuration sequencer. It uses a plain valid/ready handshake.
//
// Parameters:
//   INST_W  - width of one PE instruction word
//
// Signals:
//   s_valid - producer has an instruction word on s_data
//   s_ready - sequencer accepts a word this cycle
//   s_data  - instruction word
//
// Modports:
//   master  - producer side (drives s_valid/s_data, observes s_ready)
//   slave   - sequencer side (observes s_valid/s_data, drives s_ready)
// ---------------------------------------------------------------------------
interface pe_cfg_sequencer_if #(
  parameter int INST_W = 28
);
  logic              s_valid;
  logic              s_ready;
  logic [INST_W-1:0] s_data;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/pe_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// pe_cfg_sequencer
//
// Configuration and run sequencer for an array of PEs. A sequence has these
// steps:
//   1. Clear the PEs for one cycle.
//   2. Load NUM_PE*n instruction words in PE-major order. Each PE receives
//      n consecutive words, one per context.
//   3. Leave one idle gap cycle.
//   4. Issue n run strobes. The run_hold input can stall these strobes.
//   5. Let the PE pipeline drain for two cycles.
//   6. Pulse done.
//
// Parameters:
//   NUM_PE  - number of PEs (one init_en bit each)
//   INST_W  - PE instruction width
//   DEPTH   - PE context buffer depth; num_ctx is clamped to this value
//   CTX_W   - width of num_ctx
//
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   start         - begins a sequence; sampled only when idle
//   num_ctx       - contexts per PE; sampled together with start
//   run_hold      - suppresses the run strobe while high
//   s             - instruction stream (slave side of pe_cfg_sequencer_if)
//   pe_rst        - PE reset: rst, or the single clear cycle
//   pe_inst       - registered instruction bus shared by all PEs
//   init_en       - registered one-hot per-PE init strobe
//   run           - PE run strobe
//   busy          - high whenever a sequence is in progress
//   done          - one-cycle pulse at the end of a sequence
//   stall_cycles  - optional. Counts LOAD cycles without s_valid plus RUN
//                   cycles with run_hold.
//
// Optional feature: define PE_CFG_STALL_CNT_EN to add the stall_cycles
// output and its counter.
// ---------------------------------------------------------------------------
module pe_cfg_sequencer #(
  parameter int NUM_PE = 16,
  parameter int INST_W = 28,
  parameter int DEPTH  = 16,
  parameter int CTX_W  = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CTX_W-1:0]    num_ctx,
  input  logic                run_hold,
  pe_cfg_sequencer_if.slave   s,
  output logic                pe_rst,
  output logic [INST_W-1:0]   pe_inst,
  output logic [NUM_PE-1:0]   init_en,
  output logic                run,
  output logic                busy,
  output logic                done
`ifdef PE_CFG_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cycles
`endif
);

  localparam int PE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  localparam logic [CTX_W-1:0] DEPTH_C = CTX_W'(DEPTH);
  localparam logic [PE_W-1:0]  LAST_PE = PE_W'(NUM_PE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_LOAD,
    ST_GAP,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t           state;
  logic [CTX_W-1:0] n_lat;      // clamped context count for this sequence
  logic [CTX_W-1:0] ctx_idx;    // context being loaded into the current PE
  logic [PE_W-1:0]  pe_idx;     // PE currently being loaded
  logic [CTX_W-1:0] run_cnt;    // run strobes issued so far
  logic             drain_cnt;  // second drain cycle flag

  logic [CTX_W-1:0] n_clamped;
  logic [CTX_W-1:0] n_last;
  logic             hs;

  assign n_clamped = (num_ctx > DEPTH_C) ? DEPTH_C : num_ctx;
  assign n_last    = n_lat - CTX_W'(1);

  // These outputs decode the state register directly. s_ready must drop in
  // the cycle after the final handshake, and that happens because the
  // state has already moved to GAP.
  assign s.s_ready = (state == ST_LOAD);
  assign hs        = s.s_valid & s.s_ready;
  assign run       = (state == ST_RUN) & ~run_hold;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign pe_rst    = rst | (state == ST_CLR);

  // NOTE: sequential state is written with non-blocking assignments so that
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      n_lat     <= '0;
      ctx_idx   <= '0;
      pe_idx    <= '0;
      run_cnt   <= '0;
      drain_cnt <= 1'b0;
      pe_inst   <= '0;
      init_en   <= '0;
    end else begin
      // The init strobe lasts only one cycle per accepted word. pe_inst
      // keeps the last word so the bus stays quiet during RUN.
      init_en <= '0;
      if (hs) begin
        pe_inst <= s.s_data;
        init_en <= NUM_PE'(1) << pe_idx;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            n_lat <= n_clamped;
            state <= ST_CLR;
          end
        end

        ST_CLR: begin
          ctx_idx   <= '0;
          pe_idx    <= '0;
          run_cnt   <= '0;
          drain_cnt <= 1'b0;
          state     <= (n_lat == '0) ? ST_DONE : ST_LOAD;
        end

        ST_LOAD: begin
          if (hs) begin
            if (ctx_idx == n_last) begin
              ctx_idx <= '0;
              if (pe_idx == LAST_PE) begin
                pe_idx <= '0;
                state  <= ST_GAP;
              end else begin
                pe_idx <= pe_idx + PE_W'(1);
              end
            end else begin
              ctx_idx <= ctx_idx + CTX_W'(1);
            end
          end
        end

        // In this cycle the final init_en is visible and run is held low.
        // Without the gap, the PE would give init priority over run and
        // lose the first run strobe.
        ST_GAP: state <= ST_RUN;

        ST_RUN: begin
          if (run) begin
            run_cnt <= run_cnt + CTX_W'(1);
            if (run_cnt == n_last) state <= ST_DRAIN;
          end
        end

        // Two cycles: one for the PE instruction register, one for the
        // result register.
        ST_DRAIN: begin
          drain_cnt <= ~drain_cnt;
          if (drain_cnt) state <= ST_DONE;
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PE_CFG_STALL_CNT_EN
  // The count is held after DONE, so software can read it until the next
  // sequence clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (state == ST_CLR) begin
      stall_cycles <= '0;
    end else if (((state == ST_LOAD) && !s.s_valid) ||
                 ((state == ST_RUN) && run_hold)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pe_cfg_sequencer
//
// Self-checking bench for pe_cfg_sequencer with NUM_PE=4, DEPTH=16.
//
// Each accepted instruction word pushes an expected entry onto a
// scoreboard queue. The entry holds the target PE (derived from the word
// index and the context count), the data, and the cycle in which its
// init strobe must appear. Every cycle, each init strobe pops the queue
// and is compared against the entry.
//
// Cycle numbers are relative to the cycle in which start is sampled.
// ---------------------------------------------------------------------------
module tb_pe_cfg_sequencer;

  localparam int NPE   = 4;
  localparam int IW    = 28;
  localparam int DEP   = 16;
  localparam int CW    = $clog2(DEP) + 1;

  typedef struct {
    int            pe;
    logic [IW-1:0] data;
    int            due;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [CW-1:0]   num_ctx;
  logic            run_hold;
  logic            pe_rst;
  logic [IW-1:0]   pe_inst;
  logic [NPE-1:0]  init_en;
  logic            run;
  logic            busy;
  logic            done;
`ifdef PE_CFG_STALL_CNT_EN
  logic [31:0]     stall_cycles;
`endif

  pe_cfg_sequencer_if #(.INST_W(IW)) sif ();

  pe_cfg_sequencer #(
    .NUM_PE (NPE),
    .INST_W (IW),
    .DEPTH  (DEP),
    .CTX_W  (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_ctx  (num_ctx),
    .run_hold (run_hold),
    .s        (sif),
    .pe_rst   (pe_rst),
    .pe_inst  (pe_inst),
    .init_en  (init_en),
    .run      (run),
    .busy     (busy),
    .done     (done)
`ifdef PE_CFG_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   t0     = 0;
  exp_t sb_q[$];

  // Model state and per-sequence statistics.
  int cur_n;
  int words_seen;
  int init_pulses;
  int run_pulses;
  int first_run_rel;
  int last_run_rel;
  int ready_seen;
  int done_count;
  int done_rel;
  int busy_drop;

  // Runs one clock cycle. Outputs are sampled at the falling edge, and the
  // task returns 1 time unit after the rising edge, which is when inputs
  // are driven.
  task automatic tick();
    exp_t           e;
    logic [NPE-1:0] exp_mask;
    @(negedge clk);
    if (init_en !== '0) begin
      init_pulses++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL init_unexpected: cycle %0d init_en=%b, none pending", cyc - t0, init_en);
      end else begin
        e        = sb_q.pop_front();
        exp_mask = NPE'(1) << e.pe;
        if (init_en !== exp_mask || pe_inst !== e.data || cyc !== e.due) begin
          errors++;
          $display("FAIL init_word: cycle %0d got init_en=%b pe_inst=%h, expected init_en=%b pe_inst=%h at cycle %0d",
                   cyc - t0, init_en, pe_inst, exp_mask, e.data, e.due - t0);
        end
      end
    end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      checks++;
      errors++;
      $display("FAIL init_missing: cycle %0d init_en=0, expected strobe for data %h", cyc - t0, sb_q[0].data);
      void'(sb_q.pop_front());
    end
    if (!rst && sif.s_valid && sif.s_ready) begin
      e.pe   = (cur_n > 0) ? words_seen / cur_n : 0;
      e.data = sif.s_data;
      e.due  = cyc + 1;
      sb_q.push_back(e);
      words_seen++;
    end
    if (run) begin
      run_pulses++;
      if (first_run_rel < 0) first_run_rel = cyc - t0;
      last_run_rel = cyc - t0;
    end
    if (sif.s_ready) ready_seen++;
    if (done) begin
      done_count++;
      done_rel = cyc - t0;
    end
    if (!busy && cyc > t0 && done_count == 0) busy_drop++;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic begin_seq(input int nctx);
    sb_q.delete();
    cur_n         = (nctx > DEP) ? DEP : nctx;
    words_seen    = 0;
    init_pulses   = 0;
    run_pulses    = 0;
    first_run_rel = -1;
    last_run_rel  = -1;
    ready_seen    = 0;
    done_count    = 0;
    done_rel      = -1;
    busy_drop     = 0;
    t0            = cyc;
    start         = 1'b1;
    num_ctx       = CW'(nctx);
    tick();
    start         = 1'b0;
  endtask

  // Sends count words (base, base+1, ...). After gap_at words have been
  // accepted, s_valid is held low for gap_len cycles.
  task automatic stream(input int count, input int base, input int gap_at, input int gap_len);
    int  sent   = 0;
    int  gapped = 0;
    int  budget = 0;
    bit  hs;
    while (sent < count && budget < 2000) begin
      if (sent == gap_at && gapped < gap_len) begin
        sif.s_valid = 1'b0;
        gapped++;
        tick();
      end else begin
        sif.s_valid = 1'b1;
        sif.s_data  = IW'(base + sent);
        hs          = sif.s_ready;
        tick();
        if (hs) sent++;
      end
      budget++;
    end
    sif.s_valid = 1'b0;
    checks++;
    if (sent != count) begin
      errors++;
      $display("FAIL stream_timeout: accepted %0d words, expected %0d", sent, count);
    end
  endtask

  task automatic wait_done(input int budget);
    int b = 0;
    while (done_count == 0 && b < budget) begin
      tick();
      b++;
    end
    checks++;
    if (done_count == 0) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic wait_run(input int budget);
    int b = 0;
    while (!run && b < budget) begin
      tick();
      b++;
    end
    checks++;
    if (!run) begin
      errors++;
      $display("FAIL run_timeout: no run within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({sif.s_ready, init_en, run, busy, done} !== '0 || pe_inst !== '0 || pe_rst !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: s_ready=%b pe_inst=%h init_en=%b run=%b busy=%b done=%b pe_rst=%b, expected zeros and pe_rst=1",
               sif.s_ready, pe_inst, init_en, run, busy, done, pe_rst);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (pe_rst !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: pe_rst=%b busy=%b, expected 0 0", pe_rst, busy);
    end
  endtask

  task automatic test_basic();
    begin_seq(3);
    stream(12, 'h10, 99, 0);
    wait_done(100);
    checks++;
    if (done_rel !== 20) begin
      errors++;
      $display("FAIL basic_done_cycle: got %0d, expected 20", done_rel);
    end
    checks++;
    if (first_run_rel !== 15 || last_run_rel !== 17 || run_pulses !== 3) begin
      errors++;
      $display("FAIL basic_run: first=%0d last=%0d pulses=%0d, expected 15 17 3", first_run_rel, last_run_rel, run_pulses);
    end
    checks++;
    if (init_pulses !== 12 || sb_q.size() !== 0) begin
      errors++;
      $display("FAIL basic_init_count: pulses=%0d pending=%0d, expected 12 0", init_pulses, sb_q.size());
    end
    checks++;
    if (pe_inst !== IW'('h1B)) begin
      errors++;
      $display("FAIL basic_inst_hold: pe_inst=%h, expected 1b", pe_inst);
    end
    checks++;
    if (busy_drop !== 0) begin
      errors++;
      $display("FAIL basic_busy: busy low %0d cycles mid-sequence, expected 0", busy_drop);
    end
  endtask

  task automatic test_stalls();
    begin_seq(3);
    stream(12, 'h20, 5, 2);
    wait_run(20);
    tick();
    run_hold = 1'b1;
    tick();
    run_hold = 1'b0;
    wait_done(100);
    checks++;
    if (done_rel !== 23) begin
      errors++;
      $display("FAIL stall_done_cycle: got %0d, expected 23", done_rel);
    end
    checks++;
    if (init_pulses !== 12 || run_pulses !== 3 || sb_q.size() !== 0) begin
      errors++;
      $display("FAIL stall_counts: init=%0d run=%0d pending=%0d, expected 12 3 0", init_pulses, run_pulses, sb_q.size());
    end
`ifdef PE_CFG_STALL_CNT_EN
    tick();
    checks++;
    if (stall_cycles !== 32'd3) begin
      errors++;
      $display("FAIL stall_cycles: got %0d, expected 3", stall_cycles);
    end
`endif
  endtask

  task automatic test_zero_ctx();
    begin_seq(0);
    sif.s_valid = 1'b1;
    sif.s_data  = IW'('h77);
    wait_done(20);
    sif.s_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (done_rel !== 2) begin
      errors++;
      $display("FAIL zero_done_cycle: got %0d, expected 2", done_rel);
    end
    checks++;
    if (init_pulses !== 0 || run_pulses !== 0 || ready_seen !== 0) begin
      errors++;
      $display("FAIL zero_activity: init=%0d run=%0d ready_cycles=%0d, expected 0 0 0", init_pulses, run_pulses, ready_seen);
    end
`ifdef PE_CFG_STALL_CNT_EN
    checks++;
    if (stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL zero_stall_clear: got %0d, expected 0", stall_cycles);
    end
`endif
  endtask

  task automatic test_clamp();
    begin_seq(20);
    stream(64, 'h100, 99, 0);
    wait_done(200);
    checks++;
    if (init_pulses !== 64 || run_pulses !== 16 || ready_seen !== 64) begin
      errors++;
      $display("FAIL clamp_counts: init=%0d run=%0d ready_cycles=%0d, expected 64 16 64", init_pulses, run_pulses, ready_seen);
    end
    checks++;
    if (done_rel !== 85) begin
      errors++;
      $display("FAIL clamp_done_cycle: got %0d, expected 85", done_rel);
    end
  endtask

  task automatic test_rst_mid_load();
    begin_seq(3);
    for (int i = 0; cyc - t0 < 8 && i < 20; i++) begin
      sif.s_valid = 1'b1;
      sif.s_data  = IW'('h40 + i);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (sif.s_ready !== 1'b0 || init_en !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort: s_ready=%b init_en=%b busy=%b, expected 0 0 0", sif.s_ready, init_en, busy);
    end
    checks++;
    if (init_pulses !== 6 || sb_q.size() !== 0) begin
      errors++;
      $display("FAIL rst_partial_load: init=%0d pending=%0d, expected 6 0", init_pulses, sb_q.size());
    end
    sif.s_valid = 1'b0;
    tick();
    begin_seq(3);
    stream(12, 'h50, 99, 0);
    wait_done(100);
    checks++;
    if (done_rel !== 20 || init_pulses !== 12 || sb_q.size() !== 0) begin
      errors++;
      $display("FAIL rst_reload: done=%0d init=%0d pending=%0d, expected 20 12 0", done_rel, init_pulses, sb_q.size());
    end
  endtask

  task automatic test_start_in_run();
    begin_seq(2);
    stream(8, 'h60, 99, 0);
    wait_run(20);
    start   = 1'b1;
    num_ctx = CW'(5);
    tick();
    start   = 1'b0;
    wait_done(100);
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (done_count !== 1 || done_rel !== 15) begin
      errors++;
      $display("FAIL start_in_run_done: count=%0d cycle=%0d, expected 1 15", done_count, done_rel);
    end
    checks++;
    if (busy_drop !== 0 || busy !== 1'b0 || run_pulses !== 2 || init_pulses !== 8) begin
      errors++;
      $display("FAIL start_in_run_state: busy_drop=%0d busy=%b run=%0d init=%0d, expected 0 0 2 8",
               busy_drop, busy, run_pulses, init_pulses);
    end
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    num_ctx     = '0;
    run_hold    = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    cur_n       = 0;
    words_seen  = 0;
    done_count  = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_stalls();
    test_zero_ctx();
    test_clamp();
    test_rst_mid_load();
    test_start_in_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_cfg_sequencer.md
# pe_cfg_sequencer

Configuration and run sequencer for a row/array of PEs. Each PE holds a context buffer that is filled through a shared instruction bus plus a per-PE `init` strobe, and stepped through by a global `run` strobe. This block clears the PEs, loads a stream of instruction words into them in PE-major order, issues the run strobes for the programmed context count, waits for the PE pipeline to drain, then reports done. It sits between the host/DMA instruction stream and the PE array.

## Interface

Parameters:
- `NUM_PE`, 16: number of PEs driven (one `init_en` bit each).
- `INST_W`, 28: PE instruction width; matches `` `PE_inst ``.
- `DEPTH`, 16: PE context buffer depth; matches `` `buffer_depth ``.
- `CTX_W`, `$clog2(DEPTH)+1`: width of `num_ctx`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin a load+run sequence; sampled only in IDLE.
- `num_ctx`, in, CTX_W: contexts per PE; sampled with `start`.
- `run_hold`, in, 1: global stall; suppresses `run` while high in RUN.
- `s_valid`, in, 1: instruction stream valid.
- `s_ready`, out, 1: instruction stream ready.
- `s_data`, in, INST_W: instruction word.
- `pe_rst`, out, 1: PE reset, equal to `rst | (state==CLR)`.
- `pe_inst`, out, INST_W: registered instruction bus to all PEs.
- `init_en`, out, NUM_PE: registered one-hot PE init strobes.
- `run`, out, 1: PE run strobe.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at sequence end.

## Operation

- States: IDLE, CLR, LOAD, GAP, RUN, DRAIN, DONE.
- IDLE: if `start` is high, latch `n = min(num_ctx, DEPTH)` and go to CLR. A `start` seen outside IDLE is ignored.
- CLR (1 cycle): `pe_rst` is high, clearing the PE buffers and counters. If n==0, go to DONE; otherwise go to LOAD.
- LOAD:
  - `s_ready` is high. Each handshake (`s_valid & s_ready`) registers `pe_inst <= s_data` and `init_en <= 1<<pe_idx` for the next cycle. In every other cycle, `init_en` is 0.
  - `ctx_idx` counts 0..n-1 and then wraps, advancing `pe_idx`. Total words W = NUM_PE*n. Word k goes to PE k/n, context k%n.
  - After handshake W, go to GAP.
- GAP (1 cycle): the last `init_en` is visible and `run` is 0. This stops the PE's init-over-run priority from swallowing a run strobe.
- RUN:
  - `run = !run_hold`. `run_cnt` increments on each cycle where `run` is high.
  - When `run_cnt` reaches n (after the n-th strobe), go to DRAIN.
  - `pe_inst` holds its last value and `init_en` is 0.
- DRAIN: 2 cycles, covering the PE instruction register and the result register. Then go to DONE.
- DONE (1 cycle): `done`=1, then go to IDLE.
- `rst` at any time: state goes to IDLE, all counters clear, `pe_rst`=1 that cycle, and the sequence is abandoned.

## Timing

- Reset values: `s_ready`=0, `pe_inst`=0, `init_en`=0, `run`=0, `busy`=0, `done`=0. `pe_rst`=1 while `rst` is high.
- `start` sampled at cycle 0 → CLR in cycle 1 → LOAD from cycle 2.
- With continuous `s_valid` and no `run_hold`, `done` is high in cycle W+n+5.
- Each `s_valid` gap adds 1 cycle. Each `run_hold` cycle in RUN adds 1 cycle.
- `init_en`/`pe_inst` lag their handshake by exactly 1 cycle. Back-to-back handshakes give back-to-back strobes.
- `s_ready` is combinational from the state (high iff LOAD, and low in the cycle after handshake W).

## Configuration

- Macro: `PE_CFG_STALL_CNT_EN`.
- Defined: adds output `stall_cycles` [31:0].
  - Counts LOAD cycles with `s_valid`=0 plus RUN cycles with `run_hold`=1.
  - Cleared in CLR and by `rst`, and held after DONE until the next `start`.
- Undefined: no port and no counter logic; the rest of the behaviour is identical.

## Test plan

- NUM_PE=4, n=3, continuous `s_valid`, words 0x10..0x1B:
  - `init_en` is 0001×3, 0010×3, 0100×3, 1000×3 in cycles 3–14, with `pe_inst` = 0x10..0x1B.
  - `run` is high in cycles 15–17, and `done` is high in cycle 20.
- `s_valid` low for 2 cycles mid-LOAD and `run_hold` high for 1 cycle in RUN → `done` in cycle 23, no duplicated or missing `init_en`. With the macro, `stall_cycles`=3.
- `num_ctx`=0 → CLR, then DONE: `done` in cycle 2, no `init_en`, no `run`, `s_ready` never high.
- `num_ctx`=20 with DEPTH=16 → clamped to 16: exactly 64 words accepted and 16 `run` pulses.
- `rst` asserted in cycle 8 of LOAD:
  - Next cycle: IDLE, `s_ready`=0, `init_en`=0.
  - A fresh `start` then loads from PE0, context 0.
- `start` pulsed during RUN → ignored: single `done`, `busy` stays high until DONE.
